// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: decodes the IF/ID instruction into the execute-stage
// control bundle, registers it with operands, immediate and register indices,
// detects load-use hazards and honours external stall and flush requests.
module id_ex_control_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic [1:0]            ex_alu_op,
    output logic [9:0]            ex_funct,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic [DATA_W-1:0]     ex_rs1_data,
    output logic [DATA_W-1:0]     ex_rs2_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_illegal,
    output logic [CNT_W-1:0]      bubble_count
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Everything that travels from ID into EX in one record; an all-zero
    // record is a bubble.
    typedef struct packed {
        logic                  valid;
        logic [1:0]            alu_op;
        logic [9:0]            funct;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  branch;
        logic [DATA_W-1:0]     rs1_data;
        logic [DATA_W-1:0]     rs2_data;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  illegal;
    } ex_bundle_t;

    // Sign-extend a 13-bit immediate, then fit it to the datapath width
    // (truncating when the datapath is narrower).
    function automatic logic [DATA_W-1:0] imm_fit(input logic signed [12:0] imm_sext);
        return DATA_W'(imm_sext);
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    ex_bundle_t       ex_q, ex_d;
    ex_bundle_t       dec_p0;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
    logic             legal_p0;
    logic             uses_rs1_p0;
    logic             uses_rs2_p0;
    logic signed [12:0] imm_sext_p0;
    logic             rs1_hit;
    logic             rs2_hit;

    // ---- decode stage (p0): combinational decode of the IF/ID instruction
    // Decode opcode into control bits, source usage and the immediate.
    always_comb begin
        dec_p0          = '0;
        legal_p0        = 1'b0;
        uses_rs1_p0     = 1'b0;
        uses_rs2_p0     = 1'b0;
        imm_sext_p0     = '0;
        dec_p0.valid    = 1'b1;
        dec_p0.funct    = {id_instr[31:25], id_instr[14:12]};
        dec_p0.rs1_data = id_rs1_data;
        dec_p0.rs2_data = id_rs2_data;
        dec_p0.pc       = id_pc;
        dec_p0.rs1      = REG_ADDR_W'(id_instr[19:15]);
        dec_p0.rs2      = REG_ADDR_W'(id_instr[24:20]);
        dec_p0.rd       = REG_ADDR_W'(id_instr[11:7]);
        case (id_instr[6:0])
            OP_R: begin
                legal_p0         = 1'b1;
                uses_rs1_p0      = 1'b1;
                uses_rs2_p0      = 1'b1;
                dec_p0.alu_op    = 2'b10;
                dec_p0.reg_write = 1'b1;
            end
            OP_LD: begin
                legal_p0          = 1'b1;
                uses_rs1_p0       = 1'b1;
                imm_sext_p0       = {id_instr[31], id_instr[31:20]};
                dec_p0.alu_op     = 2'b00;
                dec_p0.alu_src    = 1'b1;
                dec_p0.mem_read   = 1'b1;
                dec_p0.mem_to_reg = 1'b1;
                dec_p0.reg_write  = 1'b1;
            end
            OP_SD: begin
                legal_p0         = 1'b1;
                uses_rs1_p0      = 1'b1;
                uses_rs2_p0      = 1'b1;
                imm_sext_p0      = {id_instr[31], id_instr[31:25], id_instr[11:7]};
                dec_p0.alu_op    = 2'b00;
                dec_p0.alu_src   = 1'b1;
                dec_p0.mem_write = 1'b1;
            end
            OP_BEQ: begin
                legal_p0      = 1'b1;
                uses_rs1_p0   = 1'b1;
                uses_rs2_p0   = 1'b1;
                imm_sext_p0   = {id_instr[31], id_instr[7], id_instr[30:25],
                                 id_instr[11:8], 1'b0};
                dec_p0.alu_op = 2'b01;
                dec_p0.branch = 1'b1;
            end
            default: begin
                legal_p0 = 1'b0;
            end
        endcase
        dec_p0.imm = imm_fit(imm_sext_p0);
    end

    // Load-use detection: a load in EX whose destination feeds a source the
    // instruction in ID really reads. x0 never creates a dependency.
    always_comb begin
        rs1_hit      = uses_rs1_p0 && (dec_p0.rs1 == ex_q.rd);
        rs2_hit      = uses_rs2_p0 && (dec_p0.rs2 == ex_q.rd);
        hazard_stall = id_valid && ex_q.valid && ex_q.mem_read &&
                       (ex_q.rd != '0) && (rs1_hit || rs2_hit);
    end

    // Next ID/EX content, in edge priority order: flush, stall, hazard,
    // empty slot, illegal opcode, then the decoded instruction.
    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d           = ex_q;
            bubble_count_d = bubble_count_q;
        end else if (hazard_stall) begin
            ex_d           = '0;
            bubble_count_d = sat_inc(bubble_count_q);
        end else if (!id_valid) begin
            ex_d = '0;
        end else if (!legal_p0) begin
            ex_d           = '0;
            ex_d.illegal   = 1'b1;
            bubble_count_d = sat_inc(bubble_count_q);
        end else begin
            ex_d = dec_p0;
        end
    end

    // ---- ID/EX register (p1): reset clears data as well as control
    // ID/EX pipeline register and bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct      = ex_q.funct;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_illegal    = ex_q.illegal;
    assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Directed, table-driven bench for id_ex_control_stage.
module tb_id_ex_control_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_instr;
    logic [7:0]  id_pc, id_rs1_data, id_rs2_data;
    logic        hazard_stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal;
    logic [1:0]  ex_alu_op;
    logic [9:0]  ex_funct;
    logic [7:0]  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, bubble_count;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;

    int checks   = 0;
    int failures = 0;

    id_ex_control_stage #(.DATA_W(8), .REG_ADDR_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_funct(ex_funct), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // ctrl = {valid, alu_op[1:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, illegal}
    localparam logic [9:0] C_R   = 10'b1_10_0_0_0_1_0_0_0;
    localparam logic [9:0] C_LD  = 10'b1_00_1_1_0_1_1_0_0;
    localparam logic [9:0] C_SD  = 10'b1_00_1_0_1_0_0_0_0;
    localparam logic [9:0] C_BEQ = 10'b1_01_0_0_0_0_0_1_0;
    localparam logic [9:0] C_BUB = 10'b0_00_0_0_0_0_0_0_0;
    localparam logic [9:0] C_ILL = 10'b0_00_0_0_0_0_0_0_1;

    typedef struct {
        bit          f, s, va;
        logic [31:0] ins;
        logic [7:0]  pc, d1, d2;
        bit          hz;
        logic [9:0]  ctrl, funct;
        logic [7:0]  imm;
        logic [4:0]  r1, r2, rd;
        logic [7:0]  epc, e1, e2, cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h03};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic vec_t mk(input bit f, input bit s, input bit va, input logic [31:0] ins,
                                input logic [7:0] pc, input logic [7:0] d1, input logic [7:0] d2,
                                input bit hz, input logic [9:0] ctrl, input logic [9:0] funct,
                                input logic [7:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic [7:0] epc, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] cnt);
        vec_t v;
        v.f = f; v.s = s; v.va = va; v.ins = ins; v.pc = pc; v.d1 = d1; v.d2 = d2;
        v.hz = hz; v.ctrl = ctrl; v.funct = funct; v.imm = imm;
        v.r1 = r1; v.r2 = r2; v.rd = rd; v.epc = epc; v.e1 = e1; v.e2 = e2; v.cnt = cnt;
        return v;
    endfunction

    // A bubble record: every data field expected to be zero.
    function automatic vec_t bub(input bit f, input bit s, input bit va, input logic [31:0] ins,
                                 input logic [7:0] pc, input bit hz, input logic [9:0] ctrl,
                                 input logic [7:0] cnt);
        return mk(f, s, va, ins, pc, 8'h5A, 8'hA5, hz, ctrl, 10'h0, 8'h0,
                  5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, cnt);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input bit f, input bit s, input bit va, input logic [31:0] ins,
                         input logic [7:0] pc, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge clk);
        flush = f; stall = s; id_valid = va; id_instr = ins;
        id_pc = pc; id_rs1_data = d1; id_rs2_data = d2;
        #1;
    endtask

    function automatic logic [31:0] ctrl_now();
        return 32'({ex_valid, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
                    ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.f, v.s, v.va, v.ins, v.pc, v.d1, v.d2);
        chk("hazard_stall", idx, 32'(hazard_stall), 32'(v.hz));
        @(posedge clk); #1;
        chk("ctrl", idx, ctrl_now(), 32'(v.ctrl));
        chk("funct", idx, 32'(ex_funct), 32'(v.funct));
        chk("imm", idx, 32'(ex_imm), 32'(v.imm));
        chk("regidx", idx, 32'({ex_rs1, ex_rs2, ex_rd}), 32'({v.r1, v.r2, v.rd}));
        chk("pc_data", idx, 32'({ex_pc, ex_rs1_data, ex_rs2_data}), 32'({v.epc, v.e1, v.e2}));
        chk("bubble_count", idx, 32'(bubble_count), 32'(v.cnt));
    endtask

    initial begin
        logic [31:0] ADD, SUB, LDM4, ADD6, LDX0, ADD7, LD16, SD, BEQ, ILL, LD0, LD9;
        ADD  = 32'h002081B3;                    // add x3,x1,x2
        SUB  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);  // sub x4,x1,x2
        LDM4 = enc_i(12'hFFC, 5'd1, 3'd3, 5'd5);      // ld x5,-4(x1)
        ADD6 = enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6);  // add x6,x5,x2
        LDX0 = enc_i(12'd8, 5'd2, 3'd3, 5'd0);        // ld x0,8(x2)
        ADD7 = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);  // add x7,x0,x0
        LD16 = enc_i(12'd16, 5'd1, 3'd3, 5'd5);       // ld x5,16(x1)
        SD   = enc_s(12'd4, 5'd5, 5'd2, 3'd3);        // sd x5,4(x2)
        BEQ  = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);     // beq x1,x2,-8
        ILL  = 32'h0000007F;
        LD0  = enc_i(12'd0, 5'd1, 3'd3, 5'd5);        // ld x5,0(x1)
        LD9  = enc_i(12'd0, 5'd3, 3'd3, 5'd9);        // ld x9,0(x3)

        //           f  s  va ins   pc     d1     d2    hz ctrl   funct   imm    r1 r2  rd  epc    e1     e2     cnt
        vecs.push_back(mk(0,0,1,ADD, 8'h10,8'h05,8'h07,0,C_R,  10'h000,8'h00,1, 2, 3, 8'h10,8'h05,8'h07,8'd0));
        vecs.push_back(mk(0,0,1,SUB, 8'h14,8'h09,8'h03,0,C_R,  10'h100,8'h00,1, 2, 4, 8'h14,8'h09,8'h03,8'd0));
        vecs.push_back(mk(0,0,1,LDM4,8'h18,8'h20,8'h11,0,C_LD, 10'h3FB,8'hFC,1, 28,5, 8'h18,8'h20,8'h11,8'd0));
        vecs.push_back(bub(0,0,1,ADD6,8'h1C,1,C_BUB,8'd1));
        vecs.push_back(mk(0,0,1,ADD6,8'h1C,8'h33,8'h44,0,C_R,  10'h000,8'h00,5, 2, 6, 8'h1C,8'h33,8'h44,8'd1));
        vecs.push_back(mk(0,0,1,LDX0,8'h20,8'h01,8'h02,0,C_LD, 10'h003,8'h08,2, 8, 0, 8'h20,8'h01,8'h02,8'd1));
        vecs.push_back(mk(0,0,1,ADD7,8'h24,8'hA1,8'hA2,0,C_R,  10'h000,8'h00,0, 0, 7, 8'h24,8'hA1,8'hA2,8'd1));
        vecs.push_back(mk(0,0,1,LD16,8'h28,8'hAA,8'hBB,0,C_LD, 10'h003,8'h10,1, 16,5, 8'h28,8'hAA,8'hBB,8'd1));
        vecs.push_back(bub(0,0,1,SD,  8'h2C,1,C_BUB,8'd2));
        vecs.push_back(mk(0,0,1,SD,  8'h2C,8'h12,8'h34,0,C_SD, 10'h003,8'h04,2, 5, 4, 8'h2C,8'h12,8'h34,8'd2));
        vecs.push_back(mk(0,0,1,BEQ, 8'h30,8'h01,8'h02,0,C_BEQ,10'h3F8,8'hF8,1, 2, 25,8'h30,8'h01,8'h02,8'd2));
        vecs.push_back(bub(0,0,1,ILL, 8'h34,0,C_ILL,8'd3));
        vecs.push_back(mk(0,0,1,ADD, 8'h38,8'h05,8'h07,0,C_R,  10'h000,8'h00,1, 2, 3, 8'h38,8'h05,8'h07,8'd3));
        vecs.push_back(bub(0,0,0,ADD, 8'h3C,0,C_BUB,8'd3));
        vecs.push_back(mk(0,0,1,LD0, 8'h40,8'h11,8'h22,0,C_LD, 10'h003,8'h00,1, 0, 5, 8'h40,8'h11,8'h22,8'd3));
        vecs.push_back(bub(1,0,1,ADD6,8'h44,1,C_BUB,8'd3));
        vecs.push_back(mk(0,0,1,ADD6,8'h44,8'h55,8'h66,0,C_R,  10'h000,8'h00,5, 2, 6, 8'h44,8'h55,8'h66,8'd3));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,1,1,LD9,8'h48,8'h77,8'h88,0,C_R,10'h000,8'h00,5, 2, 6, 8'h44,8'h55,8'h66,8'd3));
        vecs.push_back(mk(0,0,1,LD0, 8'h4C,8'h11,8'h22,0,C_LD, 10'h003,8'h00,1, 0, 5, 8'h4C,8'h11,8'h22,8'd3));
        vecs.push_back(mk(0,1,1,ADD6,8'h50,8'h99,8'hAA,1,C_LD, 10'h003,8'h00,1, 0, 5, 8'h4C,8'h11,8'h22,8'd3));
        vecs.push_back(bub(0,0,1,ADD6,8'h50,1,C_BUB,8'd4));
        vecs.push_back(mk(0,0,1,ADD6,8'h50,8'h99,8'hAA,0,C_R,  10'h000,8'h00,5, 2, 6, 8'h50,8'h99,8'hAA,8'd4));
        vecs.push_back(bub(0,0,1,ILL, 8'h54,0,C_ILL,8'd5));
        vecs.push_back(bub(0,1,1,ILL, 8'h54,0,C_ILL,8'd5));
        vecs.push_back(mk(0,0,1,ADD, 8'h58,8'h05,8'h07,0,C_R,  10'h000,8'h00,1, 2, 3, 8'h58,8'h05,8'h07,8'd5));

        // Reset state
        reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        id_instr = ADD; id_pc = 8'h10; id_rs1_data = 8'h05; id_rs2_data = 8'h07;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 0, ctrl_now(), 32'(C_BUB));
        chk("reset_data", 0, 32'({ex_pc, ex_rs1_data, ex_rs2_data}), 32'h0);
        chk("reset_misc", 0, 32'({ex_imm, ex_funct, ex_rd}), 32'h0);
        chk("reset_count", 0, 32'(bubble_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Drive the counter up to saturation with illegal opcodes (5 + 250).
        for (int k = 0; k < 250; k++) drive(0, 0, 1, ILL, 8'h60, 8'h0, 8'h0);
        @(posedge clk); #1;
        chk("sat_reach", 0, 32'(bubble_count), 32'd255);
        drive(0, 0, 1, ILL, 8'h60, 8'h0, 8'h0);
        @(posedge clk); #1;
        chk("sat_ill", 0, 32'(bubble_count), 32'd255);
        chk("sat_ill_flag", 0, ctrl_now(), 32'(C_ILL));
        drive(0, 0, 1, LD0, 8'h64, 8'h01, 8'h02);
        @(posedge clk); #1;
        drive(0, 0, 1, ADD6, 8'h68, 8'h03, 8'h04);
        chk("sat_hz", 0, 32'(hazard_stall), 32'd1);
        @(posedge clk); #1;
        chk("sat_hz_bubble", 0, ctrl_now(), 32'(C_BUB));
        chk("sat_hz_count", 0, 32'(bubble_count), 32'd255);

        // Reset arriving in the middle of a stall clears everything.
        drive(0, 0, 1, ADD, 8'h70, 8'h05, 8'h07);
        @(posedge clk); #1;
        chk("pre_rst_valid", 0, 32'(ex_valid), 32'd1);
        drive(0, 1, 1, ADD, 8'h74, 8'h05, 8'h07);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_stall_ctrl", 0, ctrl_now(), 32'(C_BUB));
        chk("rst_stall_data", 0, 32'({ex_pc, ex_rs1_data, ex_rs2_data}), 32'h0);
        chk("rst_stall_regs", 0, 32'({ex_rs1, ex_rs2, ex_rd, ex_funct}), 32'h0);
        chk("rst_stall_count", 0, 32'(bubble_count), 32'h0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
